// File: rtl/product_accumulator.sv
// Sums a programmed batch of 8-bit products into an ACC_W-bit result; optional saturation via PRODUCT_ACCUMULATOR_SATURATE_EN.
// Latency: res_valid rises on the edge after the final product is accepted.
// Backpressure: prod_ready only in ACCUM; the result is held in DONE until res_ready.
module product_accumulator #(
  parameter int ACC_W   = 12,
  parameter int COUNT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               start,
  input  logic [COUNT_W-1:0] batch_len,
  input  logic               prod_valid,
  input  logic [7:0]         prod_data,
  output logic               prod_ready,
  output logic               res_valid,
  output logic [ACC_W-1:0]   res_data,
  input  logic               res_ready,
  output logic               busy,
  output logic               ovf,
  output logic [COUNT_W:0]   terms
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   acc_next;
  logic [ACC_W:0]     sum;
  logic [COUNT_W:0]   terms_q;
  logic [COUNT_W:0]   terms_inc;
  logic [COUNT_W:0]   len_q;
  logic               ovf_q;
  logic               accept;

  assign accept    = (state_q == ACCUM) && prod_valid;
  assign terms_inc = terms_q + {{COUNT_W{1'b0}}, 1'b1};
  assign sum       = {1'b0, acc_q} + {{(ACC_W-7){1'b0}}, prod_data};

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
  // Once clamped, every later add carries again, so the clamp holds for the batch.
  assign acc_next = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign acc_next = sum[ACC_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACCUM;
      ACCUM:   if (accept && (terms_inc == len_q)) state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      terms_q <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (clear) begin
      acc_q   <= '0;
      terms_q <= '0;
      ovf_q   <= 1'b0;
    end else if ((state_q == IDLE) && start) begin
      // A zero length encodes the full 2**COUNT_W batch.
      len_q   <= (batch_len == '0) ? {1'b1, {COUNT_W{1'b0}}} : {1'b0, batch_len};
      acc_q   <= '0;
      terms_q <= '0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      acc_q   <= acc_next;
      terms_q <= terms_inc;
      ovf_q   <= ovf_q | sum[ACC_W];
    end
  end

  assign prod_ready = (state_q == ACCUM);
  assign res_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign res_data   = acc_q;
  assign ovf        = ovf_q;
  assign terms      = terms_q;

endmodule
